ram_bank: RTL and testbench

//  Parametrised simple-dual-port synchronous RAM: one write port with byte enables, one read port.

---
 rtl/ram_pkg.sv | 34 +++
 rtl/ram_bank_init_ctrl.sv | 63 ++++++
 rtl/ram_bank.sv | 167 ++++++++++++++++
 tb/tb_ram_bank.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_bank RAM slice.
// Holds the init FSM encoding, the RDW mode values and the byte-lane merge.
package ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    localparam int MAX_W   = 256;
    localparam int MAX_NBE = 256;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2
    } init_state_t;

    // Lane i of byte_w bits takes new_w when be[i] is set.
    function automatic logic [MAX_W-1:0] be_merge(
        input logic [MAX_W-1:0]   old_w,
        input logic [MAX_W-1:0]   new_w,
        input logic [MAX_NBE-1:0] be,
        input int                 byte_w
    );
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_W; i++) begin
            if (be[8'(i / byte_w)]) begin
                res[8'(i)] = new_w[8'(i)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_bank_init_ctrl.sv
// Init sequencer for ram_bank: RESET -> INIT -> RUN.
// Sweeps every word once after reset, then raises ready.
module ram_init_ctrl
    import ram_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int IW        = 10,
    parameter int INIT_ZERO = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic          o_ready,
    output logic          o_init_we,
    output logic [IW-1:0] o_init_addr
);

    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    init_state_t   r_state;
    init_state_t   w_next;
    logic [IW-1:0] r_cnt;
    logic [IW-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_RESET;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        o_ready   = 1'b0;
        o_init_we = 1'b0;
        unique case (r_state)
            ST_RESET: begin
                w_cnt_nxt = '0;
                w_next    = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            end
            ST_INIT: begin
                o_init_we = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    w_next    = ST_RUN;
                    w_cnt_nxt = '0;
                end
            end
            ST_RUN: begin
                o_ready = 1'b1;
            end
            default: begin
                w_next = ST_RESET;
            end
        endcase
    end

    assign o_init_addr = r_cnt;

endmodule

// File: rtl/ram_bank.sv
// Simple-dual-port RAM with byte enables, 1/2-cycle read latency,
// read-during-write policy, out-of-range reads and zero-fill after reset.
module ram_bank
    import ram_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BYTE_W     = 8,
    parameter int ADDR_W     = 10,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    parameter int INIT_ZERO  = 1,
    localparam int NBE       = DATA_W / BYTE_W
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NBE-1:0]    wr_be,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    generate
        if (DATA_W % BYTE_W != 0) begin : g_chk_bw
            $error("ram_bank: DATA_W must be a multiple of BYTE_W");
        end
        if (DATA_W > MAX_W || NBE > MAX_NBE) begin : g_chk_max
            $error("ram_bank: DATA_W too wide for be_merge");
        end
        if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_chk_depth
            $error("ram_bank: DEPTH must be in 1..2**ADDR_W");
        end
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_chk_lat
            $error("ram_bank: RD_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_init_we;
    logic [IW-1:0]     w_init_idx;
    logic              w_wr_inr;
    logic              w_rd_inr;
    logic              w_usr_we;
    logic              w_we;
    logic [IW-1:0]     w_widx;
    logic [IW-1:0]     w_ridx;
    logic [DATA_W-1:0] w_wdata;
    logic [NBE-1:0]    w_wbe;
    logic [DATA_W-1:0] w_wr_old;
    logic [DATA_W-1:0] w_rd_old;
    logic [DATA_W-1:0] w_wr_word;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_rdw_hit;
    logic              w_rd_acc;

    logic [MAX_W-1:0]   w_old_x;
    logic [MAX_W-1:0]   w_new_x;
    logic [MAX_NBE-1:0] w_be_x;

    ram_init_ctrl #(
        .DEPTH     (DEPTH),
        .IW        (IW),
        .INIT_ZERO (INIT_ZERO)
    ) u_init (
        .i_clk       (clock),
        .i_rst_n     (reset_n),
        .o_ready     (ready),
        .o_init_we   (w_init_we),
        .o_init_addr (w_init_idx)
    );

    assign w_wr_inr = {1'b0, wr_addr} < DEPTH_X;
    assign w_rd_inr = {1'b0, rd_addr} < DEPTH_X;
    assign w_usr_we = ready & wr_en & w_wr_inr;
    assign w_we     = w_usr_we | w_init_we;

    // The init sweep owns the write port until ready.
    assign w_widx  = ready ? wr_addr[IW-1:0] : w_init_idx;
    assign w_wdata = ready ? wr_data : '0;
    assign w_wbe   = ready ? wr_be : '1;
    assign w_ridx  = rd_addr[IW-1:0];

    assign w_wr_old = r_mem[w_widx];
    assign w_rd_old = r_mem[w_ridx];

    always_comb begin
        w_old_x = '0;
        w_new_x = '0;
        w_be_x  = '0;
        w_old_x[DATA_W-1:0] = w_wr_old;
        w_new_x[DATA_W-1:0] = w_wdata;
        w_be_x[NBE-1:0]     = w_wbe;
        w_wr_word = DATA_W'(be_merge(w_old_x, w_new_x,
                                     w_be_x, BYTE_W));
    end

    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_widx] <= w_wr_word;
        end
    end

    assign w_rdw_hit = (RDW_MODE == RDW_WRITE_FIRST)
                     && w_usr_we && w_rd_inr
                     && (rd_addr == wr_addr);
    assign w_rd_word = w_rdw_hit ? w_wr_word : w_rd_old;
    assign w_rd_acc  = ready & rd_en;

    logic              r_v1;
    logic              r_e1;
    logic [DATA_W-1:0] r_d1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_v1 <= 1'b0;
            r_e1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_e1 <= ~w_rd_inr;
                r_d1 <= w_rd_inr ? w_rd_word : '0;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              r_v2;
            logic              r_e2;
            logic [DATA_W-1:0] r_d2;

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_v2 <= 1'b0;
                    r_e2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_e2 <= r_e1;
                        r_d2 <= r_d1;
                    end
                end
            end

            assign rd_valid = r_v2;
            assign rd_err   = r_e2;
            assign rd_data  = r_d2;
        end else begin : g_lat1
            assign rd_valid = r_v1;
            assign rd_err   = r_e1;
            assign rd_data  = r_d1;
        end
    endgenerate

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: three configurations share one stimulus,
// a = 16w/lat1/read-first, b = 16w/lat2/write-first, c = 1000w/lat1.
module tb_ram_bank;

    logic        clk = 1'b0;
    logic        rst_ab;
    logic        rst_c;
    logic        wr_en;
    logic        rd_en;
    logic [9:0]  wr_addr;
    logic [9:0]  rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    logic        rdy_a, v_a, e_a;
    logic [31:0] d_a;
    logic        rdy_b, v_b, e_b;
    logic [31:0] d_b;
    logic        rdy_c, v_c, e_c;
    logic [31:0] d_c;

    logic        ra_v, ra_e, rb_v, rb_e, rc_v, rc_e;
    logic [31:0] ra_d, rb_d, rc_d;

    int n_tot = 0;
    int n_bad = 0;
    int z_a, z_b, viol;

    always #5 clk = ~clk;

    ram_bank #(
        .DATA_W(32), .BYTE_W(8), .ADDR_W(5), .DEPTH(16),
        .RD_LATENCY(1), .RDW_MODE(0), .INIT_ZERO(1)
    ) dut_a (
        .clock(clk), .reset_n(rst_ab), .ready(rdy_a),
        .wr_en(wr_en), .wr_addr(wr_addr[4:0]),
        .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr[4:0]),
        .rd_valid(v_a), .rd_data(d_a), .rd_err(e_a)
    );

    ram_bank #(
        .DATA_W(32), .BYTE_W(8), .ADDR_W(5), .DEPTH(16),
        .RD_LATENCY(2), .RDW_MODE(1), .INIT_ZERO(1)
    ) dut_b (
        .clock(clk), .reset_n(rst_ab), .ready(rdy_b),
        .wr_en(wr_en), .wr_addr(wr_addr[4:0]),
        .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr[4:0]),
        .rd_valid(v_b), .rd_data(d_b), .rd_err(e_b)
    );

    ram_bank #(
        .DATA_W(32), .BYTE_W(8), .ADDR_W(10), .DEPTH(1000),
        .RD_LATENCY(1), .RDW_MODE(0), .INIT_ZERO(1)
    ) dut_c (
        .clock(clk), .reset_n(rst_c), .ready(rdy_c),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(v_c), .rd_data(d_c), .rd_err(e_c)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a,
                      input logic [31:0] d,
                      input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        tick;
        wr_en = 1'b0;
    endtask

    // a/c results land one cycle after issue, b two cycles.
    task automatic rd(input logic [9:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick;
        rd_en = 1'b0;
        ra_v = v_a; ra_e = e_a; ra_d = d_a;
        rc_v = v_c; rc_e = e_c; rc_d = d_c;
        tick;
        rb_v = v_b; rb_e = e_b; rb_d = d_b;
    endtask

    task automatic wait_ready(output int za, output int zb,
                              output int nv);
        za = 0;
        zb = 0;
        nv = 0;
        for (int k = 0; k < 100; k++) begin
            tick;
            if (v_a || v_b) nv++;
            if (!rdy_a) za++;
            if (!rdy_b) zb++;
            if (rdy_a && rdy_b) break;
        end
    endtask

    initial begin
        rst_ab  = 1'b0;
        rst_c   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b1;
        wr_addr = '0;
        rd_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        repeat (3) tick;

        chk("rst_ready", rdy_a, 0);
        chk("rst_valid", v_a, 0);
        chk("rst_data", d_a, 0);
        chk("rst_err", e_a, 0);
        chk("rst_valid_b", v_b, 0);

        rst_ab = 1'b1;
        rst_c  = 1'b1;
        wait_ready(z_a, z_b, viol);
        chk("init_len_a", z_a, 16);
        chk("init_len_b", z_b, 16);
        chk("init_novalid", viol, 0);

        for (int i = 0; i < 16; i++) begin
            rd(10'(i));
            chk("zero_a", ra_d, 0);
            chk("zero_b", rb_d, 0);
        end
        chk("zero_valid_a", ra_v, 1);
        chk("zero_valid_b", rb_v, 1);

        wr(5, 32'h11223344, 4'b1111);
        wr(5, 32'hAABBCCDD, 4'b0101);
        rd(5);
        chk("be_a", ra_d, 32'h11BB33DD);
        chk("be_b", rb_d, 32'h11BB33DD);

        wr(6, 32'h12345678, 4'b0000);
        rd(6);
        chk("be_none", ra_d, 0);

        wr_en   = 1'b1;
        wr_addr = 3;
        wr_data = 32'hDEADBEEF;
        wr_be   = 4'b1111;
        rd_en   = 1'b1;
        rd_addr = 3;
        tick;
        wr_en = 1'b0;
        chk("rdw_a_same", d_a, 32'h0);
        chk("rdw_a_same_v", v_a, 1);
        tick;
        rd_en = 1'b0;
        chk("rdw_a_next", d_a, 32'hDEADBEEF);
        chk("rdw_b_same", d_b, 32'hDEADBEEF);
        tick;
        chk("rdw_b_next", d_b, 32'hDEADBEEF);

        wr(0, 32'hA0A0A0A0, 4'b1111);
        wr(1, 32'hA1A1A1A1, 4'b1111);
        wr(2, 32'hA2A2A2A2, 4'b1111);
        rd_en   = 1'b1;
        rd_addr = 0;
        tick;
        chk("lat_n0_v", v_b, 0);
        rd_addr = 1;
        tick;
        chk("lat_n1_v", v_b, 1);
        chk("lat_n1_d", d_b, 32'hA0A0A0A0);
        rd_addr = 2;
        tick;
        rd_en = 1'b0;
        chk("lat_n2_v", v_b, 1);
        chk("lat_n2_d", d_b, 32'hA1A1A1A1);
        tick;
        chk("lat_n3_v", v_b, 1);
        chk("lat_n3_d", d_b, 32'hA2A2A2A2);
        tick;
        chk("lat_n4_v", v_b, 0);
        chk("lat_n4_hold", d_b, 32'hA2A2A2A2);

        wr(20, 32'h55555555, 4'b1111);
        rd(20);
        chk("oor_a_v", ra_v, 1);
        chk("oor_a_err", ra_e, 1);
        chk("oor_a_d", ra_d, 0);
        chk("oor_b_err", rb_e, 1);
        rd(4);
        chk("oor_a_alias", ra_d, 0);
        chk("oor_a_alias_err", ra_e, 0);

        wr(12, 32'h0BADF00D, 4'b1111);
        rd(12);
        chk("pre_rst_d", ra_d, 32'h0BADF00D);
        rst_ab = 1'b0;
        tick;
        tick;
        rst_ab = 1'b1;
        repeat (7) tick;
        rst_ab  = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 12;
        tick;
        tick;
        chk("mid_rst_ready", rdy_a, 0);
        chk("mid_rst_valid", v_a, 0);
        rst_ab = 1'b1;
        wait_ready(z_a, z_b, viol);
        chk("reinit_len_a", z_a, 16);
        chk("reinit_len_b", z_b, 16);
        chk("reinit_novalid", viol, 0);
        rd(12);
        chk("reinit_clear_a", ra_d, 0);
        chk("reinit_clear_b", rb_d, 0);

        for (int k = 0; k < 3000; k++) begin
            if (rdy_c) break;
            tick;
        end
        chk("c_ready", rdy_c, 1);
        wr(10, 32'hCAFEF00D, 4'b1111);
        wr(1010, 32'h12345678, 4'b1111);
        rd(1010);
        chk("c_oor_v", rc_v, 1);
        chk("c_oor_err", rc_e, 1);
        chk("c_oor_d", rc_d, 0);
        rd(10);
        chk("c_alias_d", rc_d, 32'hCAFEF00D);
        chk("c_alias_err", rc_e, 0);
        rd(999);
        chk("c_last_err", rc_e, 0);
        chk("c_last_d", rc_d, 0);
        rd(1000);
        chk("c_edge_err", rc_e, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
